ysyx_lsu: RTL and testbench
===========================

YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum number of WAIT-state cycles before a load is aborted.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  EXU request valid.
REQ-005 in_ready  output  1  LSU can accept a request.
REQ-006 in_addr  input  32  effective address (ALU result).
REQ-007 in_wdata  input  32  store data (rs2).
REQ-008 in_ld / in_st  input  1 each  load or store request; neither set means pass-through.
REQ-009 in_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-010 in_unsigned  input  1  zero-extend the load result; when low, sign-extend.
REQ-011 bus_req  output  1  memory request.
REQ-012 bus_we  output  1  write request.
REQ-013 bus_addr  output  32  word-aligned address.
REQ-014 bus_wdata  output  32  write data.
REQ-015 bus_wmask  output  4  byte-lane write mask.
REQ-016 bus_gnt  input  1  request accepted.
REQ-017 bus_rvalid  input  1  read data valid.
REQ-018 bus_rdata  input  32  read data.
REQ-019 out_valid  output  1  result valid to WBU.
REQ-020 out_ready  input  1  WBU accepts the result.
REQ-021 out_rdata  output  32  extended load data, or 0.
REQ-022 out_err  output  1  access aborted (timeout, or misaligned access per REQ-036).

Function
REQ-023 The block SHALL implement four states, IDLE, REQ, WAIT and DONE, with in_ready=1 only in IDLE.
REQ-024 On in_valid&in_ready the block SHALL latch addr, wdata, ld, st, size and unsigned, and go to REQ if ld|st, otherwise to DONE with out_rdata=0, giving 1-cycle latency.
REQ-025 When ld and st are both set, the block SHALL treat the request as a store.
REQ-026 In REQ the block SHALL assert bus_req and hold bus_we, bus_addr, bus_wdata and bus_wmask stable until bus_gnt.
REQ-027 On bus_gnt a store SHALL go to DONE, and a load SHALL go to WAIT.
REQ-028 bus_addr SHALL equal {addr[31:2],2'b00}.
REQ-029 bus_wmask SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] truncated to 4 bits for half, and 4'b1111 for word.
REQ-030 bus_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-031 bus_rvalid SHALL be ignored outside WAIT, including the cycle of bus_gnt.
REQ-032 In WAIT, on bus_rvalid the block SHALL shift bus_rdata right by 8*addr[1:0], sign- or zero-extend it per size and unsigned, register it into out_rdata, and go to DONE.
REQ-033 The WAIT cycle counter SHALL reset on entry to WAIT; if it reaches TIMEOUT without bus_rvalid, the block SHALL go to DONE with out_err=1 and out_rdata=0, and bus_rvalid arriving in that same cycle SHALL take priority.
REQ-034 In DONE the block SHALL hold out_valid=1 and keep out_rdata and out_err stable until out_ready, then go to IDLE; the next request is accepted no earlier than the following cycle.
REQ-035 bus_req SHALL be 0 in IDLE, WAIT and DONE.

Configuration
REQ-036 With macro YSYX_LSU_MISALIGN_CHK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go from IDLE directly to DONE with out_err=1, out_rdata=0 and no bus_req.
REQ-037 Without YSYX_LSU_MISALIGN_CHK_EN, misaligned accesses SHALL be issued per REQ-028 to REQ-032, out-of-word bytes SHALL be dropped, and out_err SHALL come only from timeout.

Reset
REQ-038 While rst is high, and asynchronously on its assertion, the block SHALL enter IDLE.
REQ-039 During reset, out_valid, out_err, bus_req and bus_we SHALL be 0, all latched registers and the counter SHALL be 0, and in_ready SHALL be 1 after deassertion.
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction, and a later bus_rvalid SHALL be ignored.

Verification
REQ-041 Signed byte load: lb addr 0x80000003 with bus_rdata 0x80112233 -> bus_addr 0x80000000, out_rdata 0xFFFFFF80; the same access with in_unsigned=1 -> 0x00000080.
REQ-042 Half store with delayed grant: sh addr 0x80000002, wdata 0x0000ABCD, bus_gnt delayed 3 cycles -> bus_req held for 4 cycles, bus_wmask 4'b1100, bus_wdata 0xABCDABCD, stable throughout; then out_valid with out_rdata 0.
REQ-043 Load timeout: lw with TIMEOUT=4 and no bus_rvalid -> out_err=1 and out_rdata=0 after 4 WAIT cycles.
REQ-044 Output backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_rdata held, in_ready=0; a new in_valid is not accepted until the cycle after out_ready.
REQ-045 Reset mid-load: rst pulsed in WAIT, then bus_rvalid -> state IDLE, out_valid=0, in_ready=1 after deassertion.
REQ-046 Misalignment check: lw addr 0x80000002 with the macro defined -> out_err=1 and no bus_req; with the macro undefined -> bus_req issued with bus_addr 0x80000000.

Source files
------------

// File: rtl/ysyx_lsu.sv
// Load/store unit: one outstanding access, IDLE -> REQ -> WAIT -> DONE handshake with a WAIT-state timeout.
// Optional macro YSYX_LSU_MISALIGN_CHK_EN rejects misaligned half/word accesses without touching the bus.
//
// state | meaning
// IDLE  | ready for a request from EXU
// REQ   | bus_req asserted, waiting for bus_gnt
// WAIT  | load granted, waiting for bus_rvalid or timeout
// DONE  | result held for WBU until out_ready
module ysyx_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_ld,
  input  logic        in_st,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ld_q, ld_d;
  logic          st_q, st_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   rdata_sh;
  logic [31:0]   rdata_ext;
`ifdef YSYX_LSU_MISALIGN_CHK_EN
  logic          misalign;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load data: move the addressed lane to bit 0, then extend; bytes past the word are lost.
  always_comb begin
    rdata_sh = bus_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   rdata_ext = uns_q ? {24'h0, rdata_sh[7:0]}
                                 : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   rdata_ext = uns_q ? {16'h0, rdata_sh[15:0]}
                                 : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

`ifdef YSYX_LSU_MISALIGN_CHK_EN
  always_comb begin
    case (in_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = in_addr[0];
      default: misalign = (in_addr[1:0] != 2'b00);
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    st_d    = st_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_addr;
          wdata_d = in_wdata;
          st_d    = in_st;
          ld_d    = in_ld & ~in_st;   // ld+st together behaves as a store
          size_d  = in_size;
          uns_d   = in_unsigned;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (in_ld | in_st) begin
`ifdef YSYX_LSU_MISALIGN_CHK_EN
            if (misalign) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = S_REQ;
            end
`else
            state_d = S_REQ;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = ld_q ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = rdata_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        bus_wmask = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        bus_wmask = 4'b0011 << addr_q[1:0];
        bus_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        bus_wmask = 4'b1111;
        bus_wdata = wdata_q;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = (state_q == S_REQ) & st_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign out_valid = (state_q == S_DONE);
  assign out_rdata = rdata_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu (TIMEOUT=4); misalignment expectations follow YSYX_LSU_MISALIGN_CHK_EN.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic        in_ld, in_st, in_unsigned;
  logic [1:0]  in_size;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  int total = 0;
  int bad   = 0;

  ysyx_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_unsigned(in_unsigned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1; in_ld = ld; in_st = st; in_size = sz;
    in_unsigned = uns; in_addr = a; in_wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_ld = 1'b0;
    in_st = 1'b0; in_size = 2'b00; in_unsigned = 1'b0; bus_gnt = 1'b0;
    bus_rvalid = 1'b0; bus_rdata = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_err, bus_req, bus_we} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {out_valid, out_err, bus_req, bus_we});
    end
    total++;
    if (out_rdata !== 32'h0 || bus_addr !== 32'h0) begin
      bad++; $display("FAIL reset_regs got rdata=%h addr=%h want 0/0", out_rdata, bus_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] want);
    issue(1'b1, 1'b0, 2'b00, uns, 32'h8000_0003, 32'h0);
    total++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL lb_req got req=%b we=%b addr=%h want 1/0/80000000", bus_req, bus_we, bus_addr);
    end
    // Read data offered in the grant cycle must be ignored.
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    total++;
    if (bus_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL lb_wait got req=%b valid=%b want 0/0", bus_req, out_valid);
    end
    bus_rvalid = 1'b1; bus_rdata = 32'h8011_2233;
    @(negedge clk);
    bus_rvalid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_rdata !== want || out_err !== 1'b0) begin
      bad++; $display("FAIL lb_data got v=%b d=%h e=%b want 1/%h/0", out_valid, out_rdata, out_err, want);
    end
    release_out();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL lb_idle got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_half_store();
    int reqs = 0;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h0000_ABCD);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wmask !== 4'b1100 ||
          bus_wdata !== 32'hABCD_ABCD || bus_addr !== 32'h8000_0000) begin
        bad++; $display("FAIL sh_hold[%0d] got req=%b we=%b m=%b d=%h a=%h", i,
                        bus_req, bus_we, bus_wmask, bus_wdata, bus_addr);
      end
      if (bus_req === 1'b1) reqs++;
      bus_gnt = (i == 3);
      @(negedge clk);
    end
    bus_gnt = 1'b0;
    total++;
    if (reqs != 4 || bus_req !== 1'b0 || out_valid !== 1'b1 || out_rdata !== 32'h0 || out_err !== 1'b0) begin
      bad++; $display("FAIL sh_done got reqs=%0d req=%b v=%b d=%h e=%b want 4/0/1/0/0",
                      reqs, bus_req, out_valid, out_rdata, out_err);
    end
    release_out();
  endtask

  task automatic test_byte_store_ldst();
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h8000_0101, 32'h1234_565A);
    total++;
    if (bus_we !== 1'b1 || bus_wmask !== 4'b0010 || bus_wdata !== 32'h5A5A_5A5A || bus_addr !== 32'h8000_0100) begin
      bad++; $display("FAIL sb_ldst got we=%b m=%b d=%h a=%h want 1/0010/5a5a5a5a/80000100",
                      bus_we, bus_wmask, bus_wdata, bus_addr);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL sb_ldst_done got v=%b want 1", out_valid);
    end
    release_out();
  endtask

  task automatic test_half_load_signed();
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h8001_0000;
    @(negedge clk);
    bus_rvalid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_rdata !== 32'hFFFF_8001) begin
      bad++; $display("FAIL lh_data got v=%b d=%h want 1/ffff8001", out_valid, out_rdata);
    end
    release_out();
  endtask

  task automatic test_timeout(input logic late_rvalid);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0 || bus_req !== 1'b0) begin
        bad++; $display("FAIL to_wait[%0d] got v=%b req=%b want 0/0", i, out_valid, bus_req);
      end
      if (late_rvalid && i == 3) begin
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      end
      @(negedge clk);
      bus_rvalid = 1'b0;
    end
    total++;
    if (late_rvalid) begin
      if (out_valid !== 1'b1 || out_err !== 1'b0 || out_rdata !== 32'h1234_5678) begin
        bad++; $display("FAIL to_prio got v=%b e=%b d=%h want 1/0/12345678", out_valid, out_err, out_rdata);
      end
    end else begin
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin
        bad++; $display("FAIL to_err got v=%b e=%b d=%h want 1/1/0", out_valid, out_err, out_rdata);
      end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_rvalid = 1'b0;
    in_valid = 1'b1; in_ld = 1'b0; in_st = 1'b0; in_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_rdata !== 32'hCAFE_F00D || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b want 1/cafef00d/0", i, out_valid, out_rdata, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_idle got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_rdata !== 32'h0 || out_err !== 1'b0) begin
      bad++; $display("FAIL bp_pass got v=%b d=%h e=%b want 1/0/0", out_valid, out_rdata, out_err);
    end
    release_out();
  endtask

  task automatic test_reset_mid_load();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0030, 32'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bus_req !== 1'b0) begin
      bad++; $display("FAIL rst_async got rdy=%b v=%b req=%b want 1/0/0", in_ready, out_valid, bus_req);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_mid got rdy=%b v=%b d=%h want 1/0/0", in_ready, out_valid, out_rdata);
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0);
`ifdef YSYX_LSU_MISALIGN_CHK_EN
    total++;
    if (bus_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin
      bad++; $display("FAIL mis_chk got req=%b v=%b e=%b d=%h want 0/1/1/0", bus_req, out_valid, out_err, out_rdata);
    end
`else
    total++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL mis_req got req=%b a=%h want 1/80000000", bus_req, bus_addr);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hAABB_CCDD;
    @(negedge clk);
    bus_rvalid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_err !== 1'b0 || out_rdata !== 32'h0000_AABB) begin
      bad++; $display("FAIL mis_data got v=%b e=%b d=%h want 1/0/0000aabb", out_valid, out_err, out_rdata);
    end
`endif
    release_out();
  endtask

  initial begin
    test_reset();
    test_load_byte(1'b0, 32'hFFFF_FF80);
    test_load_byte(1'b1, 32'h0000_0080);
    test_half_store();
    test_byte_store_ldst();
    test_half_load_signed();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid_load();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
